// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of the single frame-buffer write port.
// Grants one write engine at a time, holds it for a burst, revokes overlong
// grants while another engine waits, and drives registered RAM write signals.
//
// Ports:
//   clock, resetn      clock; asynchronous active-low reset
//   req/done/req_wen   per-requester request, burst-done pulse, write enable
//   req_waddr/wdata    packed per-requester address/data, slice i at i*W
//   grant              one-hot registered grant
//   mem_waddr/wdata    registered frame-buffer address/data (held when idle)
//   mem_wenable        registered frame-buffer write enable
//   busy               registered, high whenever the next state is not IDLE
//   clear_start        single-cycle full-screen clear request
//   clear_busy         high on every cycle a clear write is presented
//
// Optional feature: define FB_ARB_CLEAR_EN to build the full-screen clear
// engine. Without it clear_start is ignored and clear_busy is tied low.

module fb_write_arbiter #(
  parameter int                NUM_REQ     = 3,
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 3,
  parameter int                MAX_HOLD    = 1024,
  parameter int                FB_WORDS    = 307200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_waddr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]         req_wen,
  output logic [NUM_REQ-1:0]         grant,
  output logic [ADDR_W-1:0]          mem_waddr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_wenable,
  output logic                       busy,
  input  logic                       clear_start,
  output logic                       clear_busy
);

  localparam int IDX_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W =
    (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST =
    (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_RST =
    IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE,
    ST_CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic                busy_q, busy_d;

  logic [ADDR_W-1:0]   addr_a [NUM_REQ];
  logic [DATA_W-1:0]   data_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_waddr[g*ADDR_W +: ADDR_W];
    assign data_a[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin pick: lowest requester above last_q, else lowest at or
  // below it (the wrap-around). Descending scan leaves the lowest match.
  logic              hi_found, lo_found;
  logic [IDX_W-1:0]  hi_idx, lo_idx;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IDX_W'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_idx   = hi_found ? hi_idx : lo_idx;
  end

  logic others_wait;
  logic hold_expired;
  logic leave_grant;

  assign others_wait  = |(req & ~grant_q);
  assign hold_expired = (MAX_HOLD != 0)
                      && (hold_q == HOLD_W'(HOLD_LAST))
                      && others_wait;
  assign leave_grant  = done[last_q]
                      | ~req[last_q]
                      | hold_expired;

`ifdef FB_ARB_CLEAR_EN
  localparam int CLR_W =
    (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST =
    CLR_W'(FB_WORDS - 1);

  logic              clr_pend_q, clr_pend_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_go;

  // A request seen in IDLE is taken at once; elsewhere it waits in pend.
  assign clr_go = clr_pend_q | clear_start;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    hold_d  = hold_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
`ifdef FB_ARB_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
    clr_busy_d = 1'b0;
    clr_pend_d = clr_pend_q
               | (clear_start & (state_q != ST_CLEAR));
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef FB_ARB_CLEAR_EN
        if (clr_go) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else
`endif
        if (pick_found) begin
          state_d           = ST_GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_d            = pick_idx;
          hold_d            = '0;
        end
      end

      ST_GRANT: begin
        // Address/data only move with a real write so they hold otherwise.
        if (req_wen[last_q] & grant_q[last_q]) begin
          wen_d   = 1'b1;
          waddr_d = addr_a[last_q];
          wdata_d = data_a[last_q];
        end
        if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        if (leave_grant) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end

      ST_CLEAR: begin
`ifdef FB_ARB_CLEAR_EN
        wen_d      = 1'b1;
        waddr_d    = ADDR_W'(clr_cnt_q);
        wdata_d    = CLEAR_COLOR;
        clr_busy_d = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          clr_pend_d = 1'b0;
          state_d    = ST_RELEASE;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FB_ARB_CLEAR_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clr_pend_q <= 1'b0;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      clr_pend_q <= clr_pend_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  assign clear_busy = clr_busy_q;
`else
  logic clear_unused;
  assign clear_unused = ^{clear_start, CLEAR_COLOR, (FB_WORDS != 0)};
  assign clear_busy   = 1'b0;
`endif

  assign grant       = grant_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wenable = wen_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: scoreboard bench for the frame-buffer write arbiter.
// A port-ownership model predicts every cycle; a monitor compares.

module tb_fb_write_arbiter;

  localparam int N    = 3;
  localparam int AW   = 19;
  localparam int DW   = 3;
  localparam int DWT  = N * DW;
  localparam int MH   = 8;
  localparam int FBW  = 16;
  localparam logic [DW-1:0] CC = 3'b000;
`ifdef FB_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    done = '0;
  logic [N-1:0]    req_wen = '0;
  logic [N*AW-1:0] req_waddr = '0;
  logic [DWT-1:0]  req_wdata = '0;
  logic            clear_start = 1'b0;
  logic [N-1:0]    grant;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_wenable;
  logic            busy;
  logic            clear_busy;

  fb_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
    .MAX_HOLD(MH), .FB_WORDS(FBW), .CLEAR_COLOR(CC)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req(req), .done(done),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wen(req_wen), .grant(grant),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wenable(mem_wenable), .busy(busy),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endfunction

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          cb;
  } exp_t;

  exp_t expq[$];

  // Ownership model: owner is -1 (nobody), 0..N-1 (a requester) or
  // N (clear engine); cool counts bubble cycles before re-arbitration.
  int            owner = -1;
  int            cool = 0;
  int            last = N - 1;
  int            held = 0;
  int            cidx = 0;
  bit            pend = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clock) begin : model
    exp_t         e;
    int           prev;
    int           c;
    logic [N-1:0] oth;
    e = '0;
    if (!resetn) begin
      owner = -1; cool = 0; last = N - 1;
      held = 0; cidx = 0; pend = 0;
      m_addr = '0; m_data = '0;
    end else begin
      prev = owner;
      if (owner >= 0 && owner < N) begin
        held++;
        if (req_wen[owner]) begin
          m_addr = AW'(req_waddr >> (owner * AW));
          m_data = DW'(req_wdata >> (owner * DW));
          e.wen  = 1'b1;
        end
        oth = req;
        oth[owner] = 1'b0;
        if (done[owner] || !req[owner]
            || (held >= MH && oth != 0)) begin
          owner = -1;
          cool  = 1;
        end
      end else if (owner == N) begin
        m_addr = AW'(cidx);
        m_data = CC;
        e.wen  = 1'b1;
        e.cb   = 1'b1;
        cidx++;
        if (cidx == FBW) begin
          owner = -1; cool = 1; pend = 0;
        end
      end else if (cool > 0) begin
        cool--;
      end else if (CLR_EN && (pend || clear_start)) begin
        owner = N;
        cidx  = 0;
      end else if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (last + k) % N;
          if (req[c]) begin
            owner = c; last = c; held = 0;
            break;
          end
        end
      end
      if (CLR_EN && clear_start && prev != N) pend = 1;
      if (owner >= 0 && owner < N) e.gnt[owner] = 1'b1;
      e.busy = (owner != -1) || (cool > 0);
    end
    e.addr = m_addr;
    e.data = m_data;
    expq.push_back(e);
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("sb_grant", grant, e.gnt);
      chk("sb_wen", mem_wenable, e.wen);
      chk("sb_addr", mem_waddr, e.addr);
      chk("sb_data", mem_wdata, e.data);
      chk("sb_busy", busy, e.busy);
      chk("sb_clear_busy", clear_busy, e.cb);
    end
  end

  function automatic int idx_of(logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic wait_grant(input logic [N-1:0] want,
                            input string nm);
    int t = 0;
    while (grant !== want && t < 30) begin
      @(negedge clock);
      t++;
    end
    chk(nm, grant, want);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    resetn = 1'b0;
    req = '0; done = '0; req_wen = '0; clear_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  int           order[$];
  int           gaps[$];
  int           gap, cnt, t;
  bit           rr_done;
  logic [N-1:0] prev_g;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_wen", mem_wenable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_waddr, 0);
    chk("rst_clear_busy", clear_busy, 0);
    resetn = 1'b1;

    // single request
    @(negedge clock);
    req_waddr[AW-1:0] = 19'h00010;
    req_wdata[DW-1:0] = 3'b101;
    req_wen = 3'b001;
    req = 3'b001;
    @(negedge clock);
    chk("single_grant", grant, 3'b001);
    @(negedge clock);
    chk("single_addr", mem_waddr, 19'h00010);
    chk("single_data", mem_wdata, 3'd5);
    chk("single_wen", mem_wenable, 1);
    done = 3'b001;
    @(negedge clock);
    chk("single_release", grant, 0);
    done = '0; req = '0; req_wen = '0;
    repeat (2) @(negedge clock);

    // round robin, last winner is 0
    req = '1; req_wen = '1;
    gap = 0; cnt = 0; t = 0; rr_done = 0; prev_g = '0;
    while (!rr_done && t < 100) begin
      @(negedge clock);
      t++;
      done = '0;
      if (grant != 0) begin
        if (prev_g == 0) begin
          order.push_back(idx_of(grant));
          gaps.push_back(gap);
          cnt = 0;
        end
        cnt++;
        if (cnt == 4) begin
          done = grant;
          if (order.size() == 3) begin
            req = '0;
            rr_done = 1;
          end
        end
      end else begin
        gap = (prev_g == 0) ? gap + 1 : 1;
      end
      prev_g = grant;
    end
    @(negedge clock);
    done = '0; req_wen = '0;
    chk("rr_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("rr_first", order[0], 1);
      chk("rr_second", order[1], 2);
      chk("rr_third", order[2], 0);
      chk("rr_gap1", gaps[1], 2);
      chk("rr_gap2", gaps[2], 2);
    end
    repeat (3) @(negedge clock);

    // timeout: requester 1 holds, requester 2 waits
    do_reset();
    req = 3'b010; req_wen = 3'b010;
    wait_grant(3'b010, "to_grant1");
    req[2] = 1'b1;
    cnt = 1; t = 0;
    while (t < 200) begin
      @(negedge clock);
      t++;
      if (grant == 3'b010) cnt++;
      else break;
    end
    chk("to_len", cnt, MH);
    chk("to_gap_a", grant, 0);
    @(negedge clock);
    chk("to_gap_b", grant, 0);
    @(negedge clock);
    chk("to_grant2", grant, 3'b100);
    req = '0;
    repeat (4) @(negedge clock);

    // no other requester: no timeout
    req = 3'b010;
    wait_grant(3'b010, "hold_grant");
    cnt = 0;
    while (cnt < 120 && grant == 3'b010) begin
      @(negedge clock);
      req_wen = N'($urandom);
      cnt++;
    end
    chk("hold_long", cnt, 120);
    req = '0; req_wen = '0;
    repeat (4) @(negedge clock);

    // isolation of a non-granted write enable
    req = 3'b001;
    req_wen = 3'b100;
    wait_grant(3'b001, "iso_grant");
    repeat (4) begin
      @(negedge clock);
      chk("iso_wen", mem_wenable, 0);
    end
    req = '0; req_wen = '0;
    repeat (4) @(negedge clock);

    // clear
    req = 3'b001; req_wen = 3'b001;
    wait_grant(3'b001, "clr_owner");
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    done = 3'b001;
    @(negedge clock);
    done = '0; req = '0; req_wen = '0;
`ifdef FB_ARB_CLEAR_EN
    t = 0;
    while (clear_busy !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    for (int j = 0; j < FBW; j++) begin
      chk("clr_addr", mem_waddr, j);
      chk("clr_data", mem_wdata, CC);
      chk("clr_wen", mem_wenable, 1);
      chk("clr_busy", clear_busy, 1);
      @(negedge clock);
    end
    chk("clr_end", clear_busy, 0);
    req = 3'b010;
    wait_grant(3'b010, "clr_resume");
    req = '0;
`else
    repeat (4) begin
      @(negedge clock);
      chk("noclr_busy", clear_busy, 0);
      chk("noclr_idle", busy, 0);
    end
`endif
    repeat (4) @(negedge clock);

    // reset mid-burst
    req = 3'b001; req_wen = 3'b001;
    wait_grant(3'b001, "mrst_grant");
    @(negedge clock);
    #1;
    resetn = 1'b0;
    req = '1;
    #1;
    chk("mrst_grant0", grant, 0);
    chk("mrst_wen0", mem_wenable, 0);
    chk("mrst_busy0", busy, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("mrst_first", grant, 3'b001);
    req = '0; req_wen = '0;
    repeat (4) @(negedge clock);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
        done[i] = ($urandom_range(0, 11) == 0);
        req_waddr[i*AW +: AW] = AW'($urandom);
      end
      req_wen = N'($urandom);
      req_wdata = DWT'($urandom);
      clear_start = ($urandom_range(0, 149) == 0);
    end
    @(negedge clock);
    req = '0; done = '0; clear_start = 1'b0;
    repeat (30) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d",
             n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
